// File: rtl/redux_pkg.sv
// Shared types and widths for the Redux-V 8-bit core.
package redux_pkg;

  localparam int LARGURA_ENDERECO  = 8;
  localparam int LARGURA_INSTRUCAO = 8;
  localparam int LARGURA_CONTADOR  = 16;

  typedef enum logic [1:0] {
    INICIO = 2'd0,
    BUSCA  = 2'd1,
    PARADO = 2'd2
  } estado_busca_t;

endpackage

// File: rtl/contador_saturado.sv
// Up-counter that sticks at all-ones instead of wrapping.
module contador_saturado #(
  parameter int LARGURA = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               habilita,
  output logic [LARGURA-1:0] valor
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valor <= '0;
    end else if (habilita && (valor != '1)) begin
      valor <= valor + LARGURA'(1);
    end
  end

endmodule

// File: rtl/unidade_busca.sv
// Instruction fetch unit: drives the PC to a combinational memory and holds
// one fetched instruction for decode, with redirect, halt and end-address stop.
module unidade_busca
  import redux_pkg::*;
#(
  parameter logic [LARGURA_ENDERECO-1:0] ENDERECO_INICIAL = 8'd0,
  parameter logic [LARGURA_ENDERECO-1:0] ENDERECO_FIM     = 8'd40
) (
  input  logic                         clk,
  input  logic                         rst_n,
  output logic [LARGURA_ENDERECO-1:0]  endereco,
  input  logic [LARGURA_INSTRUCAO-1:0] instrucao,
  input  logic                         desvio_valido,
  input  logic [LARGURA_ENDERECO-1:0]  desvio_alvo,
  input  logic                         parar,
  output logic [LARGURA_INSTRUCAO-1:0] saida_instrucao,
  output logic [LARGURA_ENDERECO-1:0]  saida_pc,
  output logic                         saida_valida,
  input  logic                         saida_pronta,
  output logic                         parado,
  output logic [LARGURA_CONTADOR-1:0]  buscadas
);

  estado_busca_t               estado;
  estado_busca_t               proximo;
  logic [LARGURA_ENDERECO-1:0] pc;
  logic                        transferencia;
  logic                        slot_livre;
  logic                        captura;
  logic                        carrega_desvio;

  // Handshake: an instruction moves to decode on any edge where
  // saida_valida && saida_pronta; saida_valida never drops without a transfer
  // or a redirect flush, and the payload is stable while valid and not ready.
  assign transferencia = saida_valida && saida_pronta;
  assign slot_livre    = !saida_valida || saida_pronta;
  assign endereco      = pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado <= INICIO;
    end else begin
      estado <= proximo;
    end
  end

  always_comb begin
    proximo = estado;
    unique case (estado)
      INICIO: proximo = BUSCA;
      BUSCA: begin
        if (desvio_valido) begin
          proximo = BUSCA;
        end else if (parar || (pc == ENDERECO_FIM)) begin
          proximo = PARADO;
        end
      end
      PARADO: begin
        if (desvio_valido) begin
          proximo = BUSCA;
        end
      end
      default: proximo = INICIO;
    endcase
  end

  // Redirect outranks halt and end-address; capture needs every other
  // condition clear plus room in the output register.
  always_comb begin
    carrega_desvio = desvio_valido;
    captura        = 1'b0;
    parado         = 1'b0;
    unique case (estado)
      INICIO: captura = 1'b0;
      BUSCA: begin
        captura = !desvio_valido && !parar && (pc != ENDERECO_FIM) && slot_livre;
      end
      PARADO: parado = 1'b1;
      default: captura = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= ENDERECO_INICIAL;
    end else if (carrega_desvio) begin
      pc <= desvio_alvo;
    end else if (captura) begin
      pc <= pc + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      saida_instrucao <= '0;
      saida_pc        <= '0;
      saida_valida    <= 1'b0;
    end else if (carrega_desvio) begin
      saida_valida <= 1'b0;
    end else if (captura) begin
      saida_instrucao <= instrucao;
      saida_pc        <= pc;
      saida_valida    <= 1'b1;
    end else if (transferencia) begin
      saida_valida <= 1'b0;
    end
  end

  contador_saturado #(
    .LARGURA(LARGURA_CONTADOR)
  ) u_contador (
    .clk      (clk),
    .rst_n    (rst_n),
    .habilita (captura),
    .valor    (buscadas)
  );

endmodule

// File: tb/tb_unidade_busca.sv
// Bench for unidade_busca: directed scenarios plus random traffic, all
// checked against a transaction-level model of the fetch rules.
module tb_unidade_busca;

  localparam logic [7:0] INI = 8'd0;
  localparam logic [7:0] FIM = 8'd40;
  localparam int M_INICIO = 0;
  localparam int M_BUSCA  = 1;
  localparam int M_PARADO = 2;

  logic        clk;
  logic        rst_n;
  logic [7:0]  endereco;
  logic [7:0]  instrucao;
  logic        desvio_valido;
  logic [7:0]  desvio_alvo;
  logic        parar;
  logic [7:0]  saida_instrucao;
  logic [7:0]  saida_pc;
  logic        saida_valida;
  logic        saida_pronta;
  logic        parado;
  logic [15:0] buscadas;

  logic [7:0]  mem [256];

  int          total;
  int          bad;

  // model: pc, phase, capture count, and the output register as a queue
  logic [7:0]  m_pc;
  int          m_st;
  logic [15:0] m_cnt;
  logic [15:0] exp_q[$];

  unidade_busca #(
    .ENDERECO_INICIAL(INI),
    .ENDERECO_FIM    (FIM)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .endereco        (endereco),
    .instrucao       (instrucao),
    .desvio_valido   (desvio_valido),
    .desvio_alvo     (desvio_alvo),
    .parar           (parar),
    .saida_instrucao (saida_instrucao),
    .saida_pc        (saida_pc),
    .saida_valida    (saida_valida),
    .saida_pronta    (saida_pronta),
    .parado          (parado),
    .buscadas        (buscadas)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign instrucao = mem[endereco];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc  = INI;
    m_st  = M_INICIO;
    m_cnt = 16'h0000;
    exp_q.delete();
  endtask

  task automatic model_step(input logic d, input logic [7:0] a, input logic p, input logic r);
    logic xfer;
    xfer = (exp_q.size() != 0) && r;
    if (m_st == M_INICIO) begin
      if (d) m_pc = a;
      m_st = M_BUSCA;
    end else if (m_st == M_BUSCA) begin
      if (d) begin
        m_pc = a;
        exp_q.delete();
      end else if (p || m_pc == FIM) begin
        m_st = M_PARADO;
        if (xfer) void'(exp_q.pop_front());
      end else if (exp_q.size() == 0 || r) begin
        if (xfer) void'(exp_q.pop_front());
        exp_q.push_back({m_pc, mem[m_pc]});
        m_pc = m_pc + 8'd1;
        if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      end
    end else begin
      if (d) begin
        m_pc = a;
        exp_q.delete();
        m_st = M_BUSCA;
      end else if (xfer) begin
        void'(exp_q.pop_front());
      end
    end
  endtask

  task automatic check_outputs();
    check("endereco", 32'(endereco), 32'(m_pc));
    check("valida", 32'(saida_valida), 32'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      check("saida_pc", 32'(saida_pc), 32'(exp_q[0][15:8]));
      check("saida_ins", 32'(saida_instrucao), 32'(exp_q[0][7:0]));
    end
    check("parado", 32'(parado), 32'(m_st == M_PARADO));
    check("buscadas", 32'(buscadas), 32'(m_cnt));
  endtask

  task automatic step(input logic d, input logic [7:0] a, input logic p, input logic r);
    desvio_valido = d;
    desvio_alvo   = a;
    parar         = p;
    saida_pronta  = r;
    @(posedge clk);
    model_step(d, a, p, r);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic do_reset();
    rst_n         = 1'b0;
    desvio_valido = 1'b0;
    desvio_alvo   = 8'h00;
    parar         = 1'b0;
    saida_pronta  = 1'b0;
    #1;
    model_reset();
    check("rst_valida", 32'(saida_valida), 32'(0));
    check("rst_pc_out", 32'(saida_pc), 32'(0));
    check("rst_ins", 32'(saida_instrucao), 32'(0));
    check("rst_parado", 32'(parado), 32'(0));
    check_outputs();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_until_halt(input int budget, output logic [7:0] last_pc);
    int n;
    n = 0;
    last_pc = 8'h00;
    while (!parado && n < budget) begin
      if (saida_valida) last_pc = saida_pc;
      step(1'b0, 8'h00, 1'b0, 1'b1);
      n++;
    end
    check("halt_budget", 32'(parado), 32'(1));
  endtask

  initial begin
    logic [7:0]  last;
    logic [15:0] cnt_antes;
    total = 0;
    bad   = 0;
    rst_n = 1'b1;
    desvio_valido = 1'b0;
    desvio_alvo   = 8'h00;
    parar         = 1'b0;
    saida_pronta  = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom_range(0, 255));
    mem[0]  = 8'hB0;
    mem[1]  = 8'hB5;
    mem[2]  = 8'hBA;
    mem[41] = 8'hB0;
    #2;

    // reset release and streaming
    do_reset();
    step(1'b0, 8'h00, 1'b0, 1'b1);
    check("edge1_valida", 32'(saida_valida), 32'(0));
    step(1'b0, 8'h00, 1'b0, 1'b1);
    check("seq0_pc", 32'(saida_pc), 32'(8'h00));
    check("seq0_ins", 32'(saida_instrucao), 32'(8'hB0));
    step(1'b0, 8'h00, 1'b0, 1'b1);
    check("seq1_ins", 32'(saida_instrucao), 32'(8'hB5));
    step(1'b0, 8'h00, 1'b0, 1'b1);
    check("seq2_pc", 32'(saida_pc), 32'(8'h02));
    check("seq2_ins", 32'(saida_instrucao), 32'(8'hBA));
    check("seq_cnt", 32'(buscadas), 32'(3));

    // backpressure
    do_reset();
    step(1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b0, 1'b0);
    check("bp_ins", 32'(saida_instrucao), 32'(8'hB0));
    check("bp_pc", 32'(endereco), 32'(1));
    check("bp_cnt", 32'(buscadas), 32'(1));
    step(1'b0, 8'h00, 1'b0, 1'b1);
    check("bp_release", 32'(saida_instrucao), 32'(8'hB5));

    // end address
    do_reset();
    run_until_halt(60, last);
    check("fim_last_pc", 32'(last), 32'(39));
    check("fim_cnt", 32'(buscadas), 32'(40));
    check("fim_valida", 32'(saida_valida), 32'(0));
    step(1'b0, 8'h00, 1'b0, 1'b1);
    check("fim_hold", 32'(parado), 32'(1));

    // redirect while stalled
    step(1'b1, 8'h00, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b1, 8'd41, 1'b0, 1'b0);
    check("rd_flush", 32'(saida_valida), 32'(0));
    step(1'b0, 8'h00, 1'b0, 1'b0);
    check("rd_pc", 32'(saida_pc), 32'(41));
    check("rd_ins", 32'(saida_instrucao), 32'(8'hB0));

    // redirect beats halt, then halt, then resume
    step(1'b1, 8'd5, 1'b1, 1'b1);
    check("sim_no_halt", 32'(parado), 32'(0));
    step(1'b0, 8'h00, 1'b1, 1'b1);
    check("sim_halt", 32'(parado), 32'(1));
    step(1'b0, 8'h00, 1'b0, 1'b1);
    check("sim_stay", 32'(parado), 32'(1));
    step(1'b1, 8'h00, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    check("sim_resume_pc", 32'(saida_pc), 32'(0));
    check("sim_resume_ins", 32'(saida_instrucao), 32'(8'hB0));

    // PC wrap FE -> FF -> 00 ... up to the end address
    cnt_antes = m_cnt;
    step(1'b1, 8'hFE, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    check("wrap_fe", 32'(saida_pc), 32'(8'hFE));
    step(1'b0, 8'h00, 1'b0, 1'b1);
    check("wrap_ff", 32'(saida_pc), 32'(8'hFF));
    step(1'b0, 8'h00, 1'b0, 1'b1);
    check("wrap_00", 32'(saida_pc), 32'(8'h00));
    run_until_halt(80, last);
    check("wrap_cnt", 32'(buscadas), 32'(cnt_antes + 16'd42));

    // saturation
    force dut.u_contador.valor = 16'hFFFD;
    #1;
    release dut.u_contador.valor;
    m_cnt = 16'hFFFD;
    step(1'b1, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b0, 8'h00, 1'b0, 1'b1);
    check("sat_cnt", 32'(buscadas), 32'(16'hFFFF));

    // mid-operation reset
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b0, 8'h00, 1'b0, 1'b1);
    do_reset();

    // random traffic
    for (int i = 0; i < 1500; i++) begin
      logic       d;
      logic       p;
      logic       r;
      logic [7:0] a;
      d = ($urandom_range(0, 9) == 0);
      p = ($urandom_range(0, 9) == 0);
      r = ($urandom_range(0, 9) < 7);
      a = ($urandom_range(0, 3) == 0) ? 8'(FIM - 8'($urandom_range(0, 3)))
                                      : 8'($urandom_range(0, 255));
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end else begin
        step(d, a, p, r);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/unidade_busca.md
# unidade_busca

Instruction fetch unit for the 8-bit Redux-V core. Drives the address of the combinational 256×8 instruction memory and captures the returned instruction into a one-entry output register. Presents each instruction and its address to the decode stage with a valid/ready handshake. Supports branch redirect, an external halt, a program-end address and a saturating fetch counter.

## Interface
- ENDERECO_INICIAL, 8'd0 — PC value after reset.
- ENDERECO_FIM, 8'd40 — first address past the program; reaching it halts fetch.
- clk  in  1  — single clock, rising edge.
- rst_n  in  1  — asynchronous, active-low reset.
- endereco  out  8  — address to instruction memory; always equals PC.
- instrucao  in  8  — memory data, valid combinationally in the same cycle as endereco.
- desvio_valido  in  1  — one-cycle redirect strobe.
- desvio_alvo  in  8  — redirect target PC.
- parar  in  1  — external halt request, level-sampled.
- saida_instrucao  out  8  — captured instruction.
- saida_pc  out  8  — address of saida_instrucao.
- saida_valida  out  1  — output register holds an unconsumed instruction.
- saida_pronta  in  1  — decode accepts this cycle.
- parado  out  1  — high in state PARADO.
- buscadas  out  16  — number of captures; saturates at 16'hFFFF.

## Operation
- States: INICIO, BUSCA, PARADO.
  - INICIO: no capture. Always goes to BUSCA next cycle, unless desvio_valido is high (PC loads, still goes to BUSCA).
  - BUSCA: fetch.
  - PARADO: PC frozen, no capture.
- Transfer occurs when saida_valida && saida_pronta.
- Slot free = !saida_valida || saida_pronta.
- Per-edge priority in BUSCA, highest first:
  1. desvio_valido: pc <= desvio_alvo; saida_valida <= 0 (flush, no capture); stay BUSCA.
  2. parar: go PARADO; no capture. saida_valida clears only if a transfer occurs.
  3. pc == ENDERECO_FIM: go PARADO; no capture; same valid rule as parar.
  4. Slot free: saida_instrucao <= instrucao; saida_pc <= pc; saida_valida <= 1; pc <= pc + 1 (8-bit, 8'hFF wraps to 8'h00); buscadas <= buscadas + 1, saturating.
  5. Otherwise: stall; all registers hold.
- In PARADO:
  - A pending instruction remains valid until transferred, then saida_valida <= 0.
  - desvio_valido: pc <= desvio_alvo; saida_valida <= 0; go BUSCA. parar is ignored that cycle.
  - Otherwise stay PARADO, even if parar has deasserted.
- A transfer and a redirect in the same cycle: the transferred instruction is consumed; the register flushes.
- ENDERECO_FIM compares against the current PC only. A redirect that targets ENDERECO_FIM halts on the next BUSCA cycle.

## Timing
- Reset values (async assert): pc = ENDERECO_INICIAL, state INICIO, saida_instrucao = 8'h00, saida_pc = 8'h00, saida_valida = 0, parado = 0, buscadas = 0.
- After rst_n rises:
  - edge 1: INICIO→BUSCA.
  - edge 2: first capture; saida_valida = 1 and saida_pc = ENDERECO_INICIAL after edge 2.
- Latency: instruction at PC = A appears on saida_* one edge after the first BUSCA cycle with PC = A and a free slot.
- Throughput: one instruction per cycle while saida_pronta is held high.
- Redirect: the first instruction from target T is valid two edges after the strobe edge (one bubble).
- Outputs are registered. endereco is combinational from the PC register only.
- Reset asserted mid-operation: all state returns to reset values immediately; no partial capture.

## Structure
- Shared package `redux_pkg`:
  - typedef estado_busca_t {INICIO, BUSCA, PARADO}.
  - localparams LARGURA_ENDERECO = 8, LARGURA_INSTRUCAO = 8, LARGURA_CONTADOR = 16.
- One sub-module: `contador_saturado` (parameterised width, enable, async active-low reset) for buscadas. The PC is a plain register in the top.

## Test plan
- Reset release, ENDERECO_INICIAL = 0, memory[0..2] = B0, B5, BA, saida_pronta = 1:
  - outputs (B0,0), (B5,1), (BA,2) on consecutive cycles after edge 2;
  - buscadas = 3.
- Backpressure: hold saida_pronta = 0 for 4 cycles after the first capture → saida_instrucao stays B0, PC stays 1, buscadas stays 1; release → B5 on the next edge.
- End address: ENDERECO_FIM = 40, program occupying 0..39 →
  - last output saida_pc = 39;
  - parado rises the cycle PC = 40 is seen;
  - saida_valida drops after the last transfer;
  - buscadas = 40.
- Redirect while stalled: saida_valida = 1, saida_pronta = 0, desvio_valido with alvo = 41 (memory[41] = B0) → valid clears next edge, then (B0,41) one edge later.
- Simultaneous parar + desvio_valido in BUSCA: desvio wins, no halt. Then parar alone → PARADO. Then desvio alvo = 0 → resumes at (B0,0).
- Wrap and saturation:
  - ENDERECO_INICIAL = 8'hFE, ENDERECO_FIM = 8'h05 → saida_pc sequence FE, FF, 00, ..., 04.
  - Force buscadas to FFFF → stays at FFFF after further captures.
